// File: rtl/mem_block_reader_if.sv
// Control, RAM-port and output-stream bundle for mem_block_reader.
// Optional macro MEM_BLOCK_READER_STRIDE_EN adds the per-read address stride field.
interface mem_block_reader_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16
);
  // Transfer control
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [15:0]           length;
`ifdef MEM_BLOCK_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride;
`endif
  logic                  busy;
  logic                  done;

  // RAM second port (engine is the initiator)
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Output word stream
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  // Engine side
  modport master (
`ifdef MEM_BLOCK_READER_STRIDE_EN
    input  stride,
`endif
    input  start, base_addr, length, mem_rdata, out_ready,
    output busy, done, mem_addr, mem_we, mem_dout, out_data, out_valid, out_last
  );

  // Environment side (controller, RAM and consumer)
  modport slave (
`ifdef MEM_BLOCK_READER_STRIDE_EN
    output stride,
`endif
    output start, base_addr, length, mem_rdata, out_ready,
    input  busy, done, mem_addr, mem_we, mem_dout, out_data, out_valid, out_last
  );
endinterface

// File: rtl/mem_block_reader.sv
// Read-side DMA engine: streams a contiguous block of RAM words out through a
// small first-word-fall-through FIFO, issuing reads only when buffer space is
// guaranteed. Optional macro MEM_BLOCK_READER_STRIDE_EN enables a per-read stride.
module mem_block_reader #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_block_reader_if.master bus
);
  localparam int unsigned LEN_W = 16;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued_q;
  logic [LEN_W-1:0]      accepted_q, accepted_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [ADDR_WIDTH-1:0] incr_c;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  start_acc_c, issue_c, push_c, pop_c, out_valid_c, credit_ok_c;

`ifdef MEM_BLOCK_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;
  assign incr_c = stride_q;
`else
  assign incr_c = ADDR_WIDTH'(1);
`endif

  // Handshake and credit decode: a read may issue only if its word is sure to fit
  assign out_valid_c = (count_q != '0);
  assign pop_c       = out_valid_c && bus.out_ready;
  assign push_c      = inflight_q;
  assign start_acc_c = (state_q == IDLE) && bus.start;
  assign credit_ok_c = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
  assign issue_c     = (state_q == RUN) && (issued_q != len_q) && credit_ok_c;
  assign accepted_d  = accepted_q + LEN_W'(pop_c);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.length == '0) ? FIN : RUN;
      RUN:     if (issue_c && ((issued_q + LEN_W'(1)) == len_q)) state_d = DRAIN;
      DRAIN:   if (accepted_d == len_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs: busy tracks the upcoming state, done follows one cycle spent in FIN
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIN);
  end

  // Registered status flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Transfer parameters, read issue and accept counters, FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (!reset) begin
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
`ifdef MEM_BLOCK_READER_STRIDE_EN
      stride_q   <= '0;
`endif
    end else begin
      if (start_acc_c) begin
        len_q      <= bus.length;
        addr_q     <= bus.base_addr;
        issued_q   <= '0;
        accepted_q <= '0;
`ifdef MEM_BLOCK_READER_STRIDE_EN
        stride_q   <= bus.stride;
`endif
      end else begin
        if (issue_c) begin
          mem_addr_q <= addr_q;
          addr_q     <= addr_q + incr_c;
          issued_q   <= issued_q + LEN_W'(1);
        end
        accepted_q <= accepted_d;
      end
      inflight_q <= issue_c;
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // FIFO storage: capture the word returned for last cycle's read
  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= bus.mem_rdata;
  end

  // The credit rule must keep the FIFO from ever overflowing
  assert property (@(posedge clk) disable iff (!reset)
                   !(push_c && !pop_c && (count_q == CNT_W'(FIFO_DEPTH))));

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_dout  = '0;
  assign bus.out_data  = fifo_q[rd_ptr_q];
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_valid_c && (accepted_q == (len_q - LEN_W'(1)));
endmodule

// File: tb/tb_mem_block_reader.sv
// Bench for mem_block_reader: RAM model, scoreboard of expected words built from
// the block description, and a monitor that checks every accepted word.
module tb_mem_block_reader;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_block_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  mem_block_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [DW-1:0] ram [65536];
  assign bus.mem_rdata = ram[bus.mem_addr];

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         acc_cnt = 0;
  int         ready_mode = 0;
  int         pidx = 0;
  logic [5:0] pat = 6'b101001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready pattern: 0 = always ready, 1 = 1,0,0,1,0,1 cycle, 2 = random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin
        bus.out_ready = pat[pidx];
        pidx = (pidx + 1) % 6;
      end
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every word the consumer takes must be the next expected one
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_word: got data %0h with nothing expected at %0t", bus.out_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.out_data !== e.data || bus.out_last !== e.last) begin
          failures++;
          $display("FAIL stream_word: got data %0h last %0b expected data %0h last %0b at %0t",
                   bus.out_data, bus.out_last, e.data, e.last, $time);
        end
        acc_cnt++;
      end
    end
  end

  // Expected stream: words at base, base+stride, ... with 16-bit address wrap
  task automatic push_expect(input logic [15:0] base, input logic [15:0] len, input logic [15:0] strd);
    logic [15:0] a;
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back({(i == int'(len) - 1), ram[a]});
      a = a + strd;
    end
  endtask

  task automatic drive_start(input logic [15:0] base, input logic [15:0] len, input logic [15:0] strd);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.length    = len;
`ifdef MEM_BLOCK_READER_STRIDE_EN
    bus.stride    = strd;
`endif
  endtask

  // One transfer; timing_chk checks latencies for an always-ready consumer
  task automatic run_xfer(input string tag, input logic [15:0] base, input logic [15:0] len,
                          input logic [15:0] strd, input int rmode, input bit timing_chk,
                          input bit poke_busy);
    int          n_first;
    int          n_done;
    int          budget;
    logic [15:0] addr_before;
    ready_mode = rmode;
    budget = 8 * int'(len) + 60;
    @(posedge clk); #1;
    push_expect(base, len, strd);
    addr_before = bus.mem_addr;
    drive_start(base, len, strd);
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.base_addr = 16'($urandom);
    bus.length    = 16'($urandom);
    n_first = -1;
    n_done  = -1;
    for (int n = 0; n < budget && n_done < 0; n++) begin
      @(negedge clk);
      if (n == 0) chk({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);
      if (n == 1) chk({tag, "_mem_we_dout_zero"}, {15'd0, bus.mem_we, bus.mem_dout}, 32'd0);
      if (poke_busy && n == 3) drive_start(base + 16'h0040, len + 16'd3, strd + 16'd1);
      if (poke_busy && n == 4) bus.start = 1'b0;
      if (bus.out_valid === 1'b1 && n_first < 0) n_first = n;
      if (bus.done === 1'b1) begin
        n_done = n;
        chk({tag, "_busy_low_with_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_all_words_seen_at_done"}, 32'(exp_q.size()), 32'd0);
      end
    end
    if (n_done < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", tag, budget);
      exp_q.delete();
    end
    @(negedge clk);
    chk({tag, "_done_single_cycle"}, 32'(bus.done), 32'd0);
    if (timing_chk) begin
      if (len == 16'd0) begin
        chk({tag, "_done_latency"}, 32'(n_done), 32'd1);
        chk({tag, "_no_out_valid"}, 32'(n_first), 32'hFFFF_FFFF);
        chk({tag, "_mem_addr_unchanged"}, 32'(bus.mem_addr), 32'(addr_before));
      end else begin
        chk({tag, "_first_valid_latency"}, 32'(n_first), 32'd2);
        chk({tag, "_done_latency"}, 32'(n_done), 32'(int'(len) + 3));
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] base;
    logic [15:0] len;
    logic [15:0] strd;
    int          acc0;
    bit          got;
    bit          any_valid;

    for (int a = 0; a < 65536; a++) ram[a] = 16'($urandom);
    ram[16'h0100] = 16'h00A1; ram[16'h0101] = 16'h00B2;
    ram[16'h0102] = 16'h00C3; ram[16'h0103] = 16'h00D4;
    ram[16'h8000] = 16'h8000; ram[16'h8002] = 16'h8002; ram[16'h8004] = 16'h8004;
    ram[16'h8001] = 16'h0BAD; ram[16'h8003] = 16'h0BAD;

    reset = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
`ifdef MEM_BLOCK_READER_STRIDE_EN
    bus.stride = '0;
`endif
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_last", 32'(bus.out_last), 32'd0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    run_xfer("basic", 16'h0100, 16'd4, 16'd1, 0, 1, 0);
    run_xfer("backpressure", 16'h0100, 16'd4, 16'd1, 1, 0, 0);
    run_xfer("zero_len", 16'h1234, 16'd0, 16'd1, 0, 1, 0);
    run_xfer("wrap", 16'hFFFE, 16'd4, 16'd1, 0, 1, 0);
    chk("wrap_last_mem_addr", 32'(bus.mem_addr), 32'h0001);
    run_xfer("start_while_busy", 16'h0200, 16'd6, 16'd1, 0, 1, 1);

    // Reset in the middle of a transfer
    ready_mode = 0;
    acc0 = acc_cnt;
    @(posedge clk); #1;
    push_expect(16'h0300, 16'd8, 16'd1);
    drive_start(16'h0300, 16'd8, 16'd1);
    @(posedge clk); #1 bus.start = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 30 && !got; n++) begin
      @(negedge clk);
      if (acc_cnt >= acc0 + 2) got = 1'b1;
    end
    chk("midreset_two_words_taken", 32'(got), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    exp_q.delete();
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midreset_busy", 32'(bus.busy), 32'd0);
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_out_last", 32'(bus.out_last), 32'd0);
    chk("midreset_mem_addr", 32'(bus.mem_addr), 32'd0);
    any_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) any_valid = 1'b1;
    end
    chk("midreset_stays_empty", 32'(any_valid), 32'd0);

    run_xfer("after_reset", 16'h0100, 16'd4, 16'd1, 0, 1, 0);

`ifdef MEM_BLOCK_READER_STRIDE_EN
    run_xfer("stride2", 16'h8000, 16'd3, 16'd2, 0, 1, 0);
    run_xfer("stride0", 16'h8000, 16'd3, 16'd0, 2, 0, 0);
`endif

    for (int t = 0; t < 12; t++) begin
      base = 16'($urandom);
      if (t % 3 == 0) base = 16'hFFF0 + 16'($urandom_range(0, 15));
      len = 16'($urandom_range(1, 20));
`ifdef MEM_BLOCK_READER_STRIDE_EN
      strd = 16'($urandom_range(0, 3));
`else
      strd = 16'd1;
`endif
      run_xfer("random", base, len, strd, (t == 5) ? 1 : 2, 0, 0);
    end

    chk("scoreboard_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_block_reader.md
Name: mem_block_reader

Overview:
- Read-side DMA engine. Streams a contiguous block of 16-bit words out of the main RAM.
- Drives the RAM's second read/write port as an initiator. That port has a registered address and one-cycle read latency.
- Delivers words to a consumer (e.g. display/scan-out logic) over a valid/ready stream.
- A small internal FIFO absorbs consumer backpressure while reads are in flight.

Parameters:
- DATA_WIDTH, 16, word width of RAM data and output stream.
- ADDR_WIDTH, 16, RAM address width. Address arithmetic wraps modulo 2**ADDR_WIDTH.
- FIFO_DEPTH, 4, output buffer depth in words. Power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a transfer. Sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address. Latched on accepted start.
- length  in  16  number of words to read. Latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the last word has been accepted by the consumer.
- mem_addr  out  ADDR_WIDTH  to RAM addr2.
- mem_we  out  1  to RAM we2. Constant 0.
- mem_dout  out  DATA_WIDTH  to RAM dataIn2. Constant 0.
- mem_rdata  in  DATA_WIDTH  from RAM dataOut2. Valid one cycle after mem_addr is clocked.
- out_data  out  DATA_WIDTH  stream data, FIFO head.
- out_valid  out  1  stream valid.
- out_ready  in  1  consumer ready. Transfer occurs when out_valid && out_ready at a clock edge.
- out_last  out  1  high with out_valid on the final word of the block.

Behaviour:
- Reset (reset==0 at edge) values:
  - state=IDLE; busy=0, done=0, out_valid=0, out_last=0.
  - mem_addr=0; FIFO empty; issue and accept counters 0.
  - Reset mid-transfer aborts immediately. An in-flight read result is discarded.
- States:
  - IDLE: on start, latch base/length, go to RUN. If length==0, go to FIN instead.
  - RUN: issue reads. Go to DRAIN when issued==length.
  - DRAIN: wait until accepted==length, then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- start while busy or in FIN is ignored. No queuing.
- Read issue rule:
  - In RUN, issue a read in a cycle only if (fifo_count + inflight) < FIFO_DEPTH.
  - Issuing a read means: mem_addr = current address, then address += 1 (wrapping), issued += 1.
  - mem_addr holds its last value when not issuing.
- Read return:
  - A read issued at edge N has its data sampled from mem_rdata at edge N+1 and pushed to the FIFO.
  - The credit rule guarantees the FIFO never overflows. An overflow is a design error; assert in simulation.
- Throughput: with out_ready held high, one word per clock after a 2-cycle start-up.
  - Accepted start at edge 0; first mem_addr at edge 1; first out_valid after edge 2.
- FIFO is first-word-fall-through:
  - out_data/out_valid reflect the head.
  - A push and a pop in the same cycle leave the count unchanged.
- out_last is asserted when the head word's index == length-1.
- Counters are 16 bits. length=65535 is legal. Address wrap from 0xFFFF to 0x0000 is legal and silent.
- Data order equals address order. No word is duplicated or dropped under any out_ready pattern.

Optional Feature:
- Macro: MEM_BLOCK_READER_STRIDE_EN.
- Defined:
  - Adds input port stride [ADDR_WIDTH-1:0], latched on accepted start.
  - The address increment per read is stride instead of 1, with the same wrap rule.
  - stride=0 re-reads base_addr length times.
- Undefined: no stride port; increment is fixed at 1.

Test Plan:
- Basic block:
  - Stimulus: RAM[0x0100..0x0103]=A1,B2,C3,D4; start with base=0x0100, len=4; out_ready=1.
  - Response: four words A1,B2,C3,D4 on consecutive cycles; out_last on D4; done pulses 1 cycle after D4 accept; busy falls with done.
- Backpressure:
  - Stimulus: same block, out_ready toggling 1,0,0,1,0,1...
  - Response: order preserved; fifo_count never exceeds 4; no reads issued while (count+inflight)==4.
- Zero length:
  - Stimulus: start, len=0.
  - Response: no mem_addr change; no out_valid; done pulses exactly 2 cycles after start.
- Wrap-around:
  - Stimulus: base=0xFFFE, len=4.
  - Response: mem_addr sequence FFFE, FFFF, 0000, 0001; data matches RAM.
- Reset and start edge cases:
  - Stimulus: reset low mid-transfer after 2 words.
  - Response: next cycle busy=0, out_valid=0, FIFO empty.
  - Stimulus: start pulsed during busy.
  - Response: ignored; the original transfer completes unchanged.
- Stride (MEM_BLOCK_READER_STRIDE_EN):
  - Stimulus: base=0x8000, stride=2, len=3.
  - Response: addresses 8000, 8002, 8004.
